// File: rtl/pipeline_hazard_ctrl_pkg.sv
// Shared pipeline package: ALU, writeback and immediate-select encodings,
// plus the hazard controller state encoding and stall counter width.
package pipeline_hazard_ctrl_pkg;

    typedef enum logic [3:0] {
        ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR,
        ALU_SLL, ALU_SRL, ALU_SRA, ALU_SLT, ALU_SLTU
    } alu_op_e;

    typedef enum logic [1:0] {
        WB_ALU, WB_MEM, WB_PC4
    } wb_sel_e;

    typedef enum logic [2:0] {
        IMM_I, IMM_S, IMM_B, IMM_U, IMM_J
    } imm_sel_e;

    typedef enum logic [1:0] {
        ST_RUN, ST_FLUSH, ST_DRAIN, ST_HALTED
    } hz_state_e;

    localparam int STALL_CNT_W = 16;
    localparam logic [STALL_CNT_W-1:0] STALL_CNT_MAX = '1;

endpackage

// File: rtl/pipeline_hazard_ctrl_if.sv
// Pipeline <-> hazard controller signal bundle. The pipeline side is the
// master; the hazard controller is the slave.
interface pipeline_hazard_ctrl_if;
    import pipeline_hazard_ctrl_pkg::*;

    logic [4:0]             Rs1_D;
    logic [4:0]             Rs2_D;
    logic                   UsesRs1_D;
    logic                   UsesRs2_D;
    logic [4:0]             Rdst_E;
    logic [4:0]             Rdst_M;
    logic [4:0]             Rdst_W;
    logic                   RegWrEn_E;
    logic                   RegWrEn_M;
    logic                   RegWrEn_W;
    logic                   IsLoad_E;
    logic                   BranchTaken_E;
    logic                   halt_D;
    logic                   halt_W;
    logic                   stall_F;
    logic                   stall_D;
    logic                   nop_D;
    logic                   stall_E;
    logic                   nop_E;
    logic                   halted;
    logic [STALL_CNT_W-1:0] stall_cnt;

    modport master (
        output Rs1_D, Rs2_D, UsesRs1_D, UsesRs2_D,
        output Rdst_E, Rdst_M, Rdst_W, RegWrEn_E, RegWrEn_M, RegWrEn_W,
        output IsLoad_E, BranchTaken_E, halt_D, halt_W,
        input  stall_F, stall_D, nop_D, stall_E, nop_E, halted, stall_cnt
    );

    modport slave (
        input  Rs1_D, Rs2_D, UsesRs1_D, UsesRs2_D,
        input  Rdst_E, Rdst_M, Rdst_W, RegWrEn_E, RegWrEn_M, RegWrEn_W,
        input  IsLoad_E, BranchTaken_E, halt_D, halt_W,
        output stall_F, stall_D, nop_D, stall_E, nop_E, halted, stall_cnt
    );

endinterface

// File: rtl/pipeline_hazard_ctrl_haz_raw_cmp.sv
// Read-after-write compare of both decode sources against one downstream
// stage's destination. Register write enable is active-low.
module haz_raw_cmp
    import pipeline_hazard_ctrl_pkg::*;
(
    input  logic [4:0] rs1_i,
    input  logic [4:0] rs2_i,
    input  logic       uses_rs1_i,
    input  logic       uses_rs2_i,
    input  logic [4:0] rdst_i,
    input  logic       reg_wr_en_n_i,
    output logic       raw_o
);

    logic dst_live;

    // x0 is hardwired to zero, so a write to it never creates a dependency
    assign dst_live = (rdst_i != 5'd0) && !reg_wr_en_n_i;

    assign raw_o = dst_live &&
                   ((uses_rs1_i && (rs1_i == rdst_i)) ||
                    (uses_rs2_i && (rs2_i == rdst_i)));

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Pipeline hazard controller: load-use stalls, branch flush, halt drain.
// Build option HAZ_FORWARD_EN: when defined only E-stage load-use stalls.
//
// state  | meaning
// RUN    | normal issue, hazard stalls and branch flush applied
// FLUSH  | one bubble cycle after a taken branch
// DRAIN  | halt seen in ID, fetch held until it reaches WB
// HALTED | core stopped, leave only by reset
module pipeline_hazard_ctrl
    import pipeline_hazard_ctrl_pkg::*;
(
    input  logic                   CLK,
    input  logic                   RST,
    pipeline_hazard_ctrl_if.slave  hz
);

    hz_state_e              state_q, state_d;
    logic [STALL_CNT_W-1:0] stall_cnt_q, stall_cnt_d;

    logic raw_e, raw_m, raw_w;
    logic load_use, hazard, flush;
    logic stall_f, stall_d, nop_d, stall_e, nop_e, halted;

    haz_raw_cmp u_cmp_e (
        .rs1_i(hz.Rs1_D), .rs2_i(hz.Rs2_D),
        .uses_rs1_i(hz.UsesRs1_D), .uses_rs2_i(hz.UsesRs2_D),
        .rdst_i(hz.Rdst_E), .reg_wr_en_n_i(hz.RegWrEn_E), .raw_o(raw_e)
    );

    haz_raw_cmp u_cmp_m (
        .rs1_i(hz.Rs1_D), .rs2_i(hz.Rs2_D),
        .uses_rs1_i(hz.UsesRs1_D), .uses_rs2_i(hz.UsesRs2_D),
        .rdst_i(hz.Rdst_M), .reg_wr_en_n_i(hz.RegWrEn_M), .raw_o(raw_m)
    );

    haz_raw_cmp u_cmp_w (
        .rs1_i(hz.Rs1_D), .rs2_i(hz.Rs2_D),
        .uses_rs1_i(hz.UsesRs1_D), .uses_rs2_i(hz.UsesRs2_D),
        .rdst_i(hz.Rdst_W), .reg_wr_en_n_i(hz.RegWrEn_W), .raw_o(raw_w)
    );

    assign flush    = hz.BranchTaken_E;
    assign load_use = raw_e && hz.IsLoad_E;

`ifdef HAZ_FORWARD_EN
    assign hazard = load_use;
`else
    // Without forwarding every in-flight producer must retire before issue
    assign hazard = load_use || (raw_e && !hz.IsLoad_E) || raw_m || raw_w;
`endif

    always_comb begin
        state_d = state_q;
        stall_f = 1'b0;
        stall_d = 1'b0;
        nop_d   = 1'b0;
        stall_e = 1'b0;
        nop_e   = 1'b0;
        halted  = 1'b0;
        case (state_q)
            ST_RUN: begin
                if (flush) begin
                    nop_d   = 1'b1;
                    nop_e   = 1'b1;
                    state_d = ST_FLUSH;
                end else begin
                    stall_f = hazard;
                    stall_d = hazard;
                    nop_e   = hazard;
                    if (hz.halt_D) state_d = ST_DRAIN;
                end
            end
            ST_FLUSH: begin
                nop_d   = 1'b1;
                nop_e   = 1'b1;
                state_d = ST_RUN;
            end
            ST_DRAIN: begin
                if (flush) begin
                    // the halt was on the wrong path and has been squashed
                    nop_d   = 1'b1;
                    nop_e   = 1'b1;
                    state_d = ST_RUN;
                end else begin
                    stall_f = 1'b1;
                    nop_d   = 1'b1;
                    stall_d = hazard;
                    nop_e   = hazard;
                    if (hz.halt_W) state_d = ST_HALTED;
                end
            end
            ST_HALTED: begin
                stall_f = 1'b1;
                stall_d = 1'b1;
                stall_e = 1'b1;
                halted  = 1'b1;
            end
            default: state_d = ST_RUN;
        endcase
        if (RST) begin
            state_d = ST_RUN;
            stall_f = 1'b0;
            stall_d = 1'b0;
            nop_d   = 1'b0;
            stall_e = 1'b0;
            nop_e   = 1'b0;
            halted  = 1'b0;
        end
    end

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (stall_d && (state_q != ST_HALTED) && (stall_cnt_q != STALL_CNT_MAX))
            stall_cnt_d = stall_cnt_q + 16'd1;
    end

    always_ff @(negedge CLK) begin
        if (RST) begin
            state_q     <= ST_RUN;
            stall_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign hz.stall_F   = stall_f;
    assign hz.stall_D   = stall_d;
    assign hz.nop_D     = nop_d;
    assign hz.stall_E   = stall_e;
    assign hz.nop_E     = nop_e;
    assign hz.halted    = halted;
    assign hz.stall_cnt = stall_cnt_q;

endmodule

// File: doc/pipeline_hazard_ctrl.md
PIPELINE_HAZARD_CTRL -- requirements
Module: pipeline_hazard_ctrl

Interface
REQ-001 The block SHALL use one clock and one reset: the clock is CLK and the reset is RST, which is synchronous and active-high. All state SHALL update on the negedge of CLK.
REQ-002 Port list, one per line (name, direction, width, meaning):
- CLK  in  1  clock.
- RST  in  1  synchronous active-high reset.
- Rs1_D, Rs2_D  in  5 each  decode-stage source register numbers.
- UsesRs1_D, UsesRs2_D  in  1 each  decode instruction actually reads that source.
- Rdst_E, Rdst_M, Rdst_W  in  5 each  destination register in EX, MEM and WB.
- RegWrEn_E, RegWrEn_M, RegWrEn_W  in  1 each  active-low (0 = writes a register).
- IsLoad_E  in  1  EX instruction is a load.
- BranchTaken_E  in  1  EX redirects the PC this cycle.
- halt_D, halt_W  in  1 each  halt instruction is in ID or WB.
- stall_F  out  1  hold the PC.
- stall_D, nop_D  out  1 each  IF/ID register stall and bubble.
- stall_E, nop_E  out  1 each  ID/EX register stall and bubble.
- halted  out  1  the core is stopped.
- stall_cnt  out  16  count of stall cycles.

Function
REQ-003 A RAW hazard on stage X SHALL exist when all of these hold: UsesRsN_D=1, RsN_D==Rdst_X, Rdst_X!=0 and RegWrEn_X=0.
REQ-004 Load-use: a RAW hazard on E with IsLoad_E=1 SHALL assert stall_F, stall_D and nop_E for exactly that cycle, with nop_D=0 and stall_E=0.
REQ-005 Branch flush: BranchTaken_E=1 SHALL assert nop_D and nop_E, with every stall output low, for exactly one cycle.
REQ-006 When a branch flush and a load-use hazard occur in the same cycle, the flush SHALL take priority and the load-use stall SHALL be suppressed.
REQ-007 The FSM SHALL have exactly four states: RUN, FLUSH, DRAIN and HALTED.
- RUN: outputs are set by REQ-004 to REQ-006.
- RUN->FLUSH on BranchTaken_E; FLUSH lasts one cycle and SHALL assert nop_D and nop_E, then return to RUN.
- RUN->DRAIN on halt_D=1 with no branch flush in that cycle.
- DRAIN: asserts stall_F and nop_D every cycle; hazard stalls still apply. A branch flush during DRAIN SHALL return the FSM to RUN, because the halt was squashed.
- DRAIN->HALTED on halt_W=1.
- HALTED: stall_F, stall_D and stall_E SHALL all be held at 1, halted=1, and the state SHALL be left only by RST.
REQ-008 stall_cnt SHALL increment on every cycle in which stall_D=1 and state!=HALTED, and SHALL saturate at 16'hFFFF.
REQ-009 The no-hazard latency from an input change to an output change SHALL be zero cycles: outputs are combinational from the current inputs and the current state.

Reset
REQ-010 While RST=1 at a clock edge, the state SHALL become RUN, stall_cnt SHALL become 0 and halted SHALL become 0.
REQ-011 While RST=1, every stall and nop output SHALL be 0.
REQ-012 An RST asserted mid-DRAIN or mid-FLUSH SHALL abort that state with no residual bubble on the next cycle.

Configuration
REQ-013 The feature macro is HAZ_FORWARD_EN.
- Defined: only the E-stage load-use hazard (REQ-004) stalls; RAW hazards on M and W produce no stall.
- Undefined: a RAW hazard on any of E, M or W SHALL produce the REQ-004 stall pattern, repeated each cycle until no hazard remains.

Structure
REQ-014 The FSM state encoding and a localparam for the stall_cnt width SHALL live in the shared pipeline package, alongside the existing ALU, WB and immediate-select constants.
REQ-015 A single sub-module, haz_raw_cmp, SHALL implement the per-stage RAW compare; it SHALL be instantiated three times.

Verification
REQ-016 Load-use, one cycle, values: Rdst_E=5, IsLoad_E=1, RegWrEn_E=0, Rs1_D=5, UsesRs1_D=1 -> stall_F=stall_D=nop_E=1 for exactly one cycle, and stall_cnt=1.
REQ-017 Write to x0 never stalls, values: Rdst_E=0 with the rest as in REQ-016 -> all outputs 0.
REQ-018 Branch beats load-use, values: REQ-016 stimulus plus BranchTaken_E=1 -> nop_D=nop_E=1, stalls 0; FLUSH state for one cycle, then RUN.
REQ-019 Halt drain, values: halt_D=1, then halt_W=1 three cycles later -> stall_F=nop_D=1 for those three cycles, then halted=1 and all stalls held at 1 until RST.
REQ-020 Forwarding off, values: HAZ_FORWARD_EN undefined, Rdst_W=7, RegWrEn_W=0, Rs2_D=7, UsesRs2_D=1 -> one stall cycle. With HAZ_FORWARD_EN defined and the same stimulus -> no stall.
REQ-021 Counter saturation and reset, values: force 70000 stall cycles -> stall_cnt=16'hFFFF; then RST=1 for one edge -> stall_cnt=0 and state RUN.
